// File: rtl/gpio_pkg.sv
// Shared GPIO bank constants: register offsets, select width and the default base address.
// Software headers mirror these offsets, so change them only together.
package gpio_pkg;

  localparam int unsigned REG_SEL_W = 3;
  localparam logic [31:0] GPIO_BASE_ADDR = 32'h0300_0000;

  localparam logic [4:0] OFF_OUT  = 5'h00;
  localparam logic [4:0] OFF_DIR  = 5'h04;
  localparam logic [4:0] OFF_IN   = 5'h08;
  localparam logic [4:0] OFF_IEN  = 5'h0C;
  localparam logic [4:0] OFF_RISE = 5'h10;
  localparam logic [4:0] OFF_FALL = 5'h14;
  localparam logic [4:0] OFF_STAT = 5'h18;
  localparam logic [4:0] OFF_TGL  = 5'h1C;

  // Word index of each register within the 32-byte window.
  localparam logic [REG_SEL_W-1:0] SEL_OUT  = OFF_OUT[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_DIR  = OFF_DIR[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_IN   = OFF_IN[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_IEN  = OFF_IEN[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_RISE = OFF_RISE[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_FALL = OFF_FALL[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_STAT = OFF_STAT[4:2];
  localparam logic [REG_SEL_W-1:0] SEL_TGL  = OFF_TGL[4:2];

  function automatic logic bankHit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/gpio_input_filter.sv
// One pin's input path: synchroniser chain followed by a stability filter.
// change_o is high on the edge where filt_o is about to take the synchronised value.
module gpio_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic filt_o,
  output logic change_o
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   syncVal;
  logic                   mismatch;

  assign syncVal  = sync_q[SYNC_STAGES-1];
  assign mismatch = (syncVal != filt_q);
  assign change_o = mismatch && (count_q == CNT_LAST);
  assign filt_o   = filt_q;

  // Any sample that agrees with the filtered value restarts the stability count.
  always_comb begin
    filt_d  = filt_q;
    count_d = '0;
    if (change_o) begin
      filt_d = syncVal;
    end else if (mismatch) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      filt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
      filt_q  <= filt_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: output/direction registers, filtered inputs and
// edge-triggered interrupts with write-1-to-clear status.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS      = 28,
  parameter logic [31:0] BASE_ADDR     = GPIO_BASE_ADDR,
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  output logic [31:0]         rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] ien_q, ien_d;
  logic [NUM_PINS-1:0] rise_q, rise_d;
  logic [NUM_PINS-1:0] fall_q, fall_d;
  logic [NUM_PINS-1:0] stat_q, stat_d;

  logic [NUM_PINS-1:0] inFilt;
  logic [NUM_PINS-1:0] inChange;
  logic [NUM_PINS-1:0] setMask;
  logic [NUM_PINS-1:0] w1cMask;
  logic [NUM_PINS-1:0] wrData;
  logic [REG_SEL_W-1:0] regSel;
  logic                hit;
  logic                wrEn;
  logic                unused_ok;

  assign hit    = bankHit(addr, BASE_ADDR);
  assign regSel = addr[4:2];
  assign wrEn   = we && hit;
  assign wrData = wdata[NUM_PINS-1:0];

  // Byte-lane bits and write data above the pin count are deliberately dropped.
  assign unused_ok = ^{addr[1:0], wdata};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_input_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .pad_i   (gpio_in[i]),
      .filt_o  (inFilt[i]),
      .change_o(inChange[i])
    );
  end

  // inFilt still holds the old value on a change edge, so 0 means a rising edge.
  assign setMask = inChange & ((~inFilt & rise_q) | (inFilt & fall_q));
  assign w1cMask = (wrEn && (regSel == SEL_STAT)) ? wrData : '0;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    rise_d = rise_q;
    fall_d = fall_q;
    if (wrEn) begin
      unique case (regSel)
        SEL_OUT:  out_d  = wrData;
        SEL_DIR:  dir_d  = wrData;
        SEL_IEN:  ien_d  = wrData;
        SEL_RISE: rise_d = wrData;
        SEL_FALL: fall_d = wrData;
        SEL_TGL:  out_d  = out_q ^ wrData;
        default:  ;
      endcase
    end
    // A new event outranks a clear landing on the same edge.
    stat_d = (stat_q & ~w1cMask) | setMask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      dir_q  <= '0;
      ien_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ien_q  <= ien_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stat_q <= stat_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (regSel)
        SEL_OUT:  rdata = 32'(out_q);
        SEL_DIR:  rdata = 32'(dir_q);
        SEL_IN:   rdata = 32'(inFilt);
        SEL_IEN:  rdata = 32'(ien_q);
        SEL_RISE: rdata = 32'(rise_q);
        SEL_FALL: rdata = 32'(fall_q);
        SEL_STAT: rdata = 32'(stat_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(stat_q & ien_q);

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised memory-mapped GPIO bank, the successor to the fixed 28-pin GPIO on the CPU's IO address space (base 0x0300_0000).
- Width, base address, synchroniser depth and input glitch-filter length are all parameters.
- Adds per-pin direction, set-free toggle writes, filtered inputs, and edge-triggered interrupts with write-1-to-clear status.
- Sits beside data_mem; top routes CPU IO accesses to it and ties gpio_out/gpio_oe to pads and LEDs.

Parameters:
NUM_PINS, 28, pins in the bank; legal 1..32.
BASE_ADDR, 32'h0300_0000, bank base address; must be 32-byte aligned.
SYNC_STAGES, 2, input synchroniser flops; legal ≥2.
FILTER_CYCLES, 4, cycles an input must stay stable before IN updates; legal ≥1.

Ports:
clk  in  1  system clock (single clock domain)
reset  in  1  synchronous, active-high reset
addr  in  32  CPU data address
wdata  in  32  CPU write data
we  in  1  CPU write strobe, qualified by address match
rdata  out  32  read data, combinational from registers
gpio_in  in  NUM_PINS  asynchronous pad inputs
gpio_out  out  NUM_PINS  output data register
gpio_oe  out  NUM_PINS  output enable, 1 = drive
irq  out  1  interrupt request, level

Behaviour:
Clock and reset:
- One clock, clk. reset is synchronous and active-high.
- On reset, every register, synchroniser flop, filter counter and filtered value is 0.
- Resulting output values: gpio_out=0, gpio_oe=0, irq=0; rdata follows the decode rules below.
- Asserting reset mid-filter or mid-interrupt aborts everything; there is no pending state afterwards.

Decode:
- Bank is selected when addr[31:5]==BASE_ADDR[31:5]; addr[4:2] selects the register; addr[1:0] is ignored.
- Writes take effect on the clk edge where we=1 and the bank is selected. Unselected writes are ignored.
- Unselected reads return 0. Bits at and above NUM_PINS read 0 and ignore writes.

Register map (offset, access):
- 0x00 OUT, RW: drives gpio_out.
- 0x04 DIR, RW: drives gpio_oe.
- 0x08 IN, RO: filtered input value.
- 0x0C IRQ_EN, RW.
- 0x10 IRQ_RISE, RW: enables rising-edge capture.
- 0x14 IRQ_FALL, RW: enables falling-edge capture.
- 0x18 IRQ_STATUS, W1C: writing 1 clears that bit, writing 0 has no effect.
- 0x1C OUT_TGL, WO: OUT <= OUT ^ wdata; reads 0.
- Write-only and read-only fields ignore the other access type.

Input path:
- Per pin: SYNC_STAGES flop chain, then a filter counter.
- If the synchronised value differs from the filtered value, the counter increments; otherwise it clears.
- When a mismatch occurs with counter==FILTER_CYCLES-1, the filtered value updates and the counter clears on that same edge.
- A pulse shorter than FILTER_CYCLES synchronised cycles never reaches IN.
- Latency: a change sampled at edge k appears in IN after edge k+SYNC_STAGES+FILTER_CYCLES-1. With defaults, IN updates 5 edges after the first sampling edge.
- IN reflects the pad regardless of DIR; loopback reads are legal.

Interrupts:
- STATUS[i] sets on the edge where the filtered value of pin i changes, if the matching IRQ_RISE[i] (0→1) or IRQ_FALL[i] (1→0) bit is set.
- STATUS sets independently of IRQ_EN.
- If a set event and a W1C of the same bit fall on the same edge, set wins.
- irq = |(IRQ_STATUS & IRQ_EN), driven directly from registers. It is therefore visible in the cycle after the set edge, and drops in the cycle after the clearing write.
- A pin held high through reset appears as a rising edge after the input latency. It sets STATUS only if IRQ_RISE was written before the filter completes.

Timing:
- OUT, DIR and OUT_TGL writes reach gpio_out/gpio_oe on the write edge, i.e. in the next cycle.
- A back-to-back OUT write followed by OUT_TGL uses the updated OUT.

Decomposition:
- Shared package gpio_pkg holds the register offset constants (OFF_OUT … OFF_TGL), the register-select width (3), and the BASE_ADDR default. top and software headers use these same constants.
- One sub-module, gpio_input_filter: a single pin's synchroniser plus filter, outputting the filtered value and a change pulse. It is generated NUM_PINS times.
- Register file, decode and interrupt logic stay in gpio_bank.

Test Plan:
- Bench parameters for all scenarios: NUM_PINS=8, FILTER_CYCLES=4, SYNC_STAGES=2.
- Reset, then read all offsets → every read 0, gpio_out=0, gpio_oe=0, irq=0. Assert reset mid-filter → IN stays 0 and no STATUS afterwards.
- Write OUT=0xFFFF_FFA5, DIR=0x0F → gpio_out=0xA5, gpio_oe=0x0F next cycle; OUT reads 0xA5. Then write OUT_TGL=0x03 → gpio_out=0xA6, and OUT_TGL reads 0.
- gpio_in[0] high for 3 cycles → IN stays 0x00. Hold it high for 4+ cycles → IN[0]=1 exactly 5 edges after the first sampling edge, with no intermediate glitch.
- Write IRQ_RISE=0x01, IRQ_EN=0x01, then drive gpio_in[0] 0→1 → STATUS=0x01 and irq=1. Write STATUS=0x01 → irq=0 next cycle. A falling edge with IRQ_FALL=0 → no set.
- W1C of STATUS[0] on the same edge a new rising edge on pin 0 is filtered → STATUS[0] remains 1 and irq stays high.
- Write to 0x0300_0020 and 0x0200_0000 with we=1 → no register changes, and reads at those addresses return 0.
